// File: rtl/tlb_op_ctrl_if.sv
// Request/completion handshake between the memory stage and the TLB op sequencer.
// master = pipeline side, slave = sequencer side.
interface tlb_op_ctrl_if;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_type;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vpn;
    logic        resp_valid;
    logic        resp_ready;

    modport master (
        output op_valid, op_type, inv_op, inv_asid, inv_vpn, resp_ready,
        input  op_ready, resp_valid
    );

    modport slave (
        input  op_valid, op_type, inv_op, inv_asid, inv_vpn, resp_ready,
        output op_ready, resp_valid
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: drain, search, single-cycle commit, respond.
// Define TLB_FILL_RR_EN to replace the fill-index LFSR with a round-robin counter.
module tlb_op_ctrl #(
    parameter int unsigned TLBNUM = 32,
    parameter int unsigned IDX_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    tlb_op_ctrl_if.slave     op_if,
    input  logic             excp_flush,
    input  logic             ertn_flush,
    input  logic             data_busy,
    output logic             busy,
    output logic             tlbsrch_en,
    input  logic             serch_tlb_finish,
    input  logic             s_found,
    input  logic [IDX_W-1:0] s_index,
    input  logic             rd_e,
    output logic             tlb_wen,
    output logic             tlb_fill_en,
    output logic [IDX_W-1:0] rand_index,
    output logic             tlbinv_en,
    output logic [4:0]       tlbinv_op,
    output logic [9:0]       tlbinv_asid,
    output logic [18:0]      tlbinv_vpn,
    output logic             srch_wb_en,
    output logic             srch_ne,
    output logic [IDX_W-1:0] srch_index,
    output logic             rd_wb_en,
    output logic             rd_entry_valid,
    output logic             resp_valid,
    output logic             resp_ready_unused_o
);

    if (TLBNUM != (32'd1 << IDX_W)) begin : g_cfg_err
        $error("TLBNUM must equal 2**IDX_W");
    end

    typedef enum logic [2:0] {StIdle, StDrain, StSrch, StSwait, StExec, StDone} state_e;

    localparam logic [2:0] OpSrch = 3'd0;
    localparam logic [2:0] OpRd   = 3'd1;
    localparam logic [2:0] OpWr   = 3'd2;
    localparam logic [2:0] OpFill = 3'd3;
    localparam logic [2:0] OpInv  = 3'd4;

`ifdef TLB_FILL_RR_EN
    localparam logic [IDX_W-1:0] IdxSeed = '0;
`else
    localparam logic [IDX_W-1:0] IdxSeed = IDX_W'(1);
`endif

    state_e           state_q, state_d;
    logic [2:0]       type_q, type_d;
    logic [4:0]       inv_op_q, inv_op_d;
    logic [9:0]       inv_asid_q, inv_asid_d;
    logic [18:0]      inv_vpn_q, inv_vpn_d;
    logic             ne_q, ne_d;
    logic [IDX_W-1:0] sidx_q, sidx_d;
    logic [IDX_W-1:0] idx_gen_q, idx_gen_d;
    logic             srch_en_q, srch_en_d;
    logic             wen_q, wen_d, fill_q, fill_d, inv_q, inv_d;
    logic             swb_q, swb_d, rwb_q, rwb_d;
    logic             resp_q, resp_d, busy_q, busy_d;
    logic             flush, accept, exec_d;

    assign flush          = excp_flush | ertn_flush;
    assign op_if.op_ready = reset & (state_q == StIdle) & ~flush;
    assign accept         = op_if.op_valid & op_if.op_ready;

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        inv_op_d   = inv_op_q;
        inv_asid_d = inv_asid_q;
        inv_vpn_d  = inv_vpn_q;
        ne_d       = ne_q;
        sidx_d     = sidx_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StDrain;
                    type_d     = op_if.op_type;
                    inv_op_d   = op_if.inv_op;
                    inv_asid_d = op_if.inv_asid;
                    inv_vpn_d  = op_if.inv_vpn;
                end
            end
            StDrain: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (!data_busy) begin
                    if (type_q == OpSrch)     state_d = StSrch;
                    else if (type_q > OpInv)  state_d = StDone;
                    else                      state_d = StExec;
                end
            end
            StSrch:  state_d = flush ? StIdle : StSwait;
            StSwait: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (serch_tlb_finish) begin
                    state_d = StExec;
                    ne_d    = ~s_found;
                    sidx_d  = s_index;
                end
            end
            // EXEC is the commit point: its strobe is already registered, a flush only drops the response
            StExec:  state_d = flush ? StIdle : StDone;
            StDone:  state_d = (flush || op_if.resp_ready) ? StIdle : StDone;
            default: state_d = StIdle;
        endcase

        exec_d    = (state_d == StExec);
        srch_en_d = (state_d == StSrch);
        swb_d     = exec_d && (type_q == OpSrch);
        rwb_d     = exec_d && (type_q == OpRd);
        wen_d     = exec_d && (type_q == OpWr);
        fill_d    = exec_d && (type_q == OpFill);
        inv_d     = exec_d && (type_q == OpInv);
        resp_d    = (state_d == StDone);
        busy_d    = (state_d != StIdle);

`ifdef TLB_FILL_RR_EN
        idx_gen_d = idx_gen_q;
        if (fill_q) begin
            idx_gen_d = (idx_gen_q == IDX_W'(TLBNUM - 1)) ? '0 : idx_gen_q + 1'b1;
        end
`else
        // Fibonacci LFSR for x^5+x^3+1; all-zero state is unreachable from the seed
        idx_gen_d = {idx_gen_q[IDX_W-2:0], idx_gen_q[IDX_W-1] ^ idx_gen_q[IDX_W-3]};
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            type_q     <= '0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vpn_q  <= '0;
            ne_q       <= 1'b0;
            sidx_q     <= '0;
            idx_gen_q  <= IdxSeed;
            srch_en_q  <= 1'b0;
            swb_q      <= 1'b0;
            rwb_q      <= 1'b0;
            wen_q      <= 1'b0;
            fill_q     <= 1'b0;
            inv_q      <= 1'b0;
            resp_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            inv_op_q   <= inv_op_d;
            inv_asid_q <= inv_asid_d;
            inv_vpn_q  <= inv_vpn_d;
            ne_q       <= ne_d;
            sidx_q     <= sidx_d;
            idx_gen_q  <= idx_gen_d;
            srch_en_q  <= srch_en_d;
            swb_q      <= swb_d;
            rwb_q      <= rwb_d;
            wen_q      <= wen_d;
            fill_q     <= fill_d;
            inv_q      <= inv_d;
            resp_q     <= resp_d;
            busy_q     <= busy_d;
        end
    end

    assign tlbsrch_en          = srch_en_q & ~flush;
    assign srch_wb_en          = swb_q;
    assign srch_ne             = ne_q;
    assign srch_index          = sidx_q;
    assign rd_wb_en            = rwb_q;
    assign rd_entry_valid      = rd_e;
    assign tlb_wen             = wen_q;
    assign tlb_fill_en         = fill_q;
    assign rand_index          = idx_gen_q;
    assign tlbinv_en           = inv_q;
    assign tlbinv_op           = inv_op_q;
    assign tlbinv_asid         = inv_asid_q;
    assign tlbinv_vpn          = inv_vpn_q;
    assign op_if.resp_valid    = resp_q;
    assign busy                = busy_q;
    assign resp_ready_unused_o = 1'b0;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: expected strobes/responses queued at accept, checked on output.
// Honours TLB_FILL_RR_EN the same way as the design.
module tb_tlb_op_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        excp_flush, ertn_flush, data_busy, serch_tlb_finish, s_found, rd_e;
    logic [4:0]  s_index;
    logic        busy, tlbsrch_en, tlb_wen, tlb_fill_en, tlbinv_en;
    logic [4:0]  rand_index, tlbinv_op, srch_index;
    logic [9:0]  tlbinv_asid;
    logic [18:0] tlbinv_vpn;
    logic        srch_wb_en, srch_ne, rd_wb_en, rd_entry_valid, spare;

    tlb_op_ctrl_if op_if ();

    tlb_op_ctrl #(.TLBNUM(32), .IDX_W(5)) dut (
        .clk                 (clk),
        .reset               (reset),
        .op_if               (op_if),
        .excp_flush          (excp_flush),
        .ertn_flush          (ertn_flush),
        .data_busy           (data_busy),
        .busy                (busy),
        .tlbsrch_en          (tlbsrch_en),
        .serch_tlb_finish    (serch_tlb_finish),
        .s_found             (s_found),
        .s_index             (s_index),
        .rd_e                (rd_e),
        .tlb_wen             (tlb_wen),
        .tlb_fill_en         (tlb_fill_en),
        .rand_index          (rand_index),
        .tlbinv_en           (tlbinv_en),
        .tlbinv_op           (tlbinv_op),
        .tlbinv_asid         (tlbinv_asid),
        .tlbinv_vpn          (tlbinv_vpn),
        .srch_wb_en          (srch_wb_en),
        .srch_ne             (srch_ne),
        .srch_index          (srch_index),
        .rd_wb_en            (rd_wb_en),
        .rd_entry_valid      (rd_entry_valid),
        .resp_valid          (op_if.resp_valid),
        .resp_ready_unused_o (spare)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          cyc;
        logic [2:0]  kind;
        logic [33:0] data;
    } exp_t;

    exp_t sq[$];
    int   rq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [4:0] lfsr_m;
    int   rr_m = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [4:0] lfsr_adv(input logic [4:0] v, input int n);
        logic [4:0] r = v;
        for (int i = 0; i < n; i++) r = {r[3:0], ^(r & 5'b10100)};
        return r;
    endfunction

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        lfsr_m <= !reset ? 5'd1 : lfsr_adv(lfsr_m, 1);
    end

    // Output monitor: strobes and response rises are popped from the scoreboard
    logic resp_prev = 1'b0;
    always @(negedge clk) begin
        int          n;
        logic [2:0]  kind;
        logic [33:0] data;
        exp_t        e;
        n = int'(srch_wb_en) + int'(rd_wb_en) + int'(tlb_wen) + int'(tlb_fill_en) + int'(tlbinv_en);
        kind = 3'd7;
        data = '0;
        if (srch_wb_en)       begin kind = 3'd0; data = 34'({srch_ne, srch_index}); end
        else if (rd_wb_en)    begin kind = 3'd1; data = 34'(rd_entry_valid); end
        else if (tlb_wen)     begin kind = 3'd2; end
        else if (tlb_fill_en) begin kind = 3'd3; data = 34'(rand_index); end
        else if (tlbinv_en)   begin kind = 3'd4; data = {tlbinv_op, tlbinv_asid, tlbinv_vpn}; end
        if (n > 1) check("strobe_onehot", 64'(n), 64'd1);
        if (n >= 1) begin
            if (sq.size() == 0) begin
                check("unexp_strobe", 64'(kind), 64'd7);
            end else begin
                e = sq.pop_front();
                check("strobe_kind", 64'(kind), 64'(e.kind));
                check("strobe_cyc", 64'(cyc), 64'(e.cyc));
                check("strobe_data", 64'(data), 64'(e.data));
            end
        end
        if (op_if.resp_valid && !resp_prev) begin
            if (rq.size() == 0) check("unexp_resp", 64'd1, 64'd0);
            else check("resp_cyc", 64'(cyc), 64'(rq.pop_front()));
        end
        resp_prev = op_if.resp_valid;
    end

    task automatic issue(input logic [2:0] op, input int busy_n, input int wait_n,
                         input logic found, input logic [4:0] sidx, input logic [4:0] iop,
                         input logic [9:0] asid, input logic [18:0] vpn, input logic rde,
                         input int flush_off, input int rr_dly);
        int   t, d, x, sw, r, e_c, f, endc;
        logic legal, srch, flushed;
        exp_t ex;
        @(negedge clk);
        op_if.op_valid = 1'b1;
        op_if.op_type  = op;
        op_if.inv_op   = iop;
        op_if.inv_asid = asid;
        op_if.inv_vpn  = vpn;
        data_busy = 1'b0; serch_tlb_finish = 1'b0; excp_flush = 1'b0;
        s_found = found; s_index = sidx; rd_e = rde; op_if.resp_ready = 1'b0;
        #1;
        check("op_ready", 64'(op_if.op_ready), 64'd1);
        t       = cyc;
        legal   = (op <= 3'd4);
        srch    = (op == 3'd0);
        flushed = (flush_off != 0);
        f       = t + flush_off;
        d       = t + 1 + busy_n;
        x       = srch ? d + 3 + wait_n : d + 1;
        sw      = d + 2 + wait_n;
        r       = legal ? x + 1 : d + 1;
        e_c     = r + rr_dly;
        endc    = flushed ? f : e_c;
        if (legal && (!flushed || f >= x)) begin
            ex.cyc  = x;
            ex.kind = op;
            case (op)
                3'd0:    ex.data = 34'({!found, sidx});
                3'd1:    ex.data = 34'(rde);
                3'd4:    ex.data = {iop, asid, vpn};
                3'd3: begin
`ifdef TLB_FILL_RR_EN
                    ex.data = 34'(rr_m);
                    rr_m    = (rr_m + 1) % 32;
`else
                    ex.data = 34'(lfsr_adv(lfsr_m, x - t));
`endif
                end
                default: ex.data = '0;
            endcase
            sq.push_back(ex);
        end
        if (!flushed) rq.push_back(r);
        for (int c = t + 1; c <= endc + 1; c++) begin
            @(negedge clk);
            op_if.op_valid   = 1'b0;
            op_if.op_type    = 3'($urandom);
            op_if.inv_op     = 5'($urandom);
            op_if.inv_asid   = 10'($urandom);
            op_if.inv_vpn    = 19'($urandom);
            data_busy        = (c <= t + busy_n);
            serch_tlb_finish = srch && (c == sw);
            excp_flush       = flushed && (c == f);
            op_if.resp_ready = !flushed && (c >= e_c);
            #1;
            if (c <= endc) begin
                check("busy", 64'(busy), 64'd1);
            end else begin
                check("idle_busy", 64'(busy), 64'd0);
                check("idle_ready", 64'(op_if.op_ready), 64'd1);
            end
            check("tlbsrch_en", 64'(tlbsrch_en),
                  64'(srch && (c == d + 1) && !(flushed && f <= c)));
        end
        data_busy = 1'b0; serch_tlb_finish = 1'b0; excp_flush = 1'b0; op_if.resp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        op_if.op_valid = 1'b1; op_if.op_type = 3'd2; op_if.resp_ready = 1'b1;
        op_if.inv_op = '0; op_if.inv_asid = '0; op_if.inv_vpn = '0;
        excp_flush = 1'b0; ertn_flush = 1'b0; data_busy = 1'b0; serch_tlb_finish = 1'b0;
        s_found = 1'b0; s_index = '0; rd_e = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_op_ready", 64'(op_if.op_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp", 64'(op_if.resp_valid), 64'd0);
        check("rst_strobes", 64'({tlb_wen, tlb_fill_en, tlbinv_en, srch_wb_en, rd_wb_en,
                                  tlbsrch_en}), 64'd0);
        check("rst_operands", 64'({tlbinv_op, tlbinv_asid, tlbinv_vpn, srch_ne, srch_index}),
              64'd0);
`ifdef TLB_FILL_RR_EN
        check("rst_index", 64'(rand_index), 64'd0);
`else
        check("rst_index", 64'(rand_index), 64'd1);
`endif
        @(negedge clk);
        op_if.op_valid = 1'b0; op_if.resp_ready = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 33; i++)
            issue(3'd3, 0, 0, 1'b0, 5'd0, 5'd0, 10'd0, 19'd0, 1'b0, 0, 0);
        issue(3'd2, 0, 0, 1'b0, 5'd0, 5'd0, 10'd0, 19'd0, 1'b0, 0, 0);
        issue(3'd0, 3, 1, 1'b1, 5'd7, 5'd0, 10'd0, 19'd0, 1'b0, 0, 0);
        issue(3'd0, 0, 0, 1'b0, 5'd12, 5'd0, 10'd0, 19'd0, 1'b0, 0, 1);
        issue(3'd1, 1, 0, 1'b0, 5'd0, 5'd0, 10'd0, 19'd0, 1'b1, 0, 2);
        issue(3'd1, 0, 0, 1'b0, 5'd0, 5'd0, 10'd0, 19'd0, 1'b0, 0, 0);
        issue(3'd4, 0, 0, 1'b0, 5'd0, 5'd5, 10'h3A, 19'h1234, 1'b0, 0, 0);
        issue(3'd6, 2, 0, 1'b0, 5'd0, 5'd0, 10'd0, 19'd0, 1'b0, 0, 1);
        issue(3'd0, 0, 3, 1'b1, 5'd9, 5'd0, 10'd0, 19'd0, 1'b0, 4, 0);
        issue(3'd3, 0, 0, 1'b0, 5'd0, 5'd0, 10'd0, 19'd0, 1'b0, 2, 0);
        issue(3'd2, 2, 0, 1'b0, 5'd0, 5'd0, 10'd0, 19'd0, 1'b0, 2, 0);

        @(negedge clk);
        op_if.op_valid = 1'b1; op_if.op_type = 3'd2; ertn_flush = 1'b1;
        #1;
        check("idle_flush_ready", 64'(op_if.op_ready), 64'd0);
        @(negedge clk);
        op_if.op_valid = 1'b0; ertn_flush = 1'b0;
        #1;
        check("idle_flush_busy", 64'(busy), 64'd0);

        issue(3'd4, 1, 0, 1'b0, 5'd0, 5'd17, 10'h155, 19'h7ABCD, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sq.size() + rq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
Sequencer for TLB management instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) issued from the memory stage. It drains in-flight data translations, takes the shared data search port, and drives the TLB write, fill and invalidate controls of the address translation block. It returns CSR write-back strobes and a completion handshake to the pipeline.

Parameters:
TLBNUM, 32, number of TLB entries.
IDX_W, 5, index width; must equal clog2(TLBNUM).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
op_valid  in  1  management op request
op_ready  out  1  request accepted when high with op_valid
op_type  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5-7 illegal
inv_op  in  5  INVTLB op, latched on accept
inv_asid  in  10  INVTLB asid, latched on accept
inv_vpn  in  19  INVTLB vpn, latched on accept
excp_flush  in  1  exception flush
ertn_flush  in  1  ertn flush
data_busy  in  1  data translation pipe holds a valid op
busy  out  1  high when not IDLE; front end must not raise data_addr_valid
tlbsrch_en  out  1  search request on the shared data port
serch_tlb_finish  in  1  search result valid
s_found  in  1  search hit
s_index  in  IDX_W  search hit index
rd_e  in  1  E bit of the entry read at csr_tlbidx.INDEX
tlb_wen  out  1  TLBWR write strobe
tlb_fill_en  out  1  TLBFILL write strobe
rand_index  out  IDX_W  fill index
tlbinv_en  out  1  invalidate strobe
tlbinv_op  out  5  latched inv_op
tlbinv_asid  out  10  latched inv_asid
tlbinv_vpn  out  19  latched inv_vpn
srch_wb_en  out  1  write TLBIDX.NE and TLBIDX.INDEX
srch_ne  out  1  not-found flag
srch_index  out  IDX_W  found index
rd_wb_en  out  1  TLBRD CSR write-back strobe
rd_entry_valid  out  1  copy of rd_e
resp_valid  out  1  op complete
resp_ready  in  1  pipeline consumes completion

Behaviour:
- States: IDLE, DRAIN, SRCH, SWAIT, EXEC, DONE. Reset puts the block in IDLE with all strobes, resp_valid, busy and latched operands at 0. op_ready reads 0 while reset is asserted. The index generator resets to 5'b00001.
- op_ready is high only in IDLE with no flush. On accept, op_type and the inv fields are latched and the state goes to DRAIN.
- DRAIN holds while data_busy=1. When data_busy=0: SRCH for op_type 0; DONE for illegal types (no strobes); EXEC for all other types.
- SRCH lasts 1 cycle: tlbsrch_en=1. It then goes to SWAIT.
- SWAIT waits for serch_tlb_finish=1. In that cycle it latches NE=!s_found and index=s_index, then goes to EXEC.
- EXEC lasts 1 cycle and asserts exactly one strobe for the latched type:
  - SRCH: srch_wb_en
  - RD: rd_wb_en, with rd_entry_valid=rd_e
  - WR: tlb_wen
  - FILL: tlb_fill_en
  - INV: tlbinv_en
  The state then goes to DONE.
- DONE holds resp_valid=1 until resp_ready=1, then returns to IDLE.
- Minimum latency from accept cycle T (data_busy=0): WR/FILL/RD/INV strobe at T+2, resp_valid at T+3. SRCH: tlbsrch_en at T+2, write-back at T+4, resp_valid at T+5.
- Flush (excp_flush | ertn_flush) in DRAIN, SRCH, SWAIT or DONE: return to IDLE next cycle with no further strobes and resp dropped. tlbsrch_en is gated by !flush in that same cycle.
- Flush in EXEC: the strobe still fires (commit point), then the state goes to IDLE without a response.
- Flush in IDLE together with op_valid: the op is not accepted.
- Index generator: 5-bit LFSR, taps x^5+x^3+1, advances every cycle. The value 0 never occurs. rand_index shows the current value and must be stable through the EXEC cycle of FILL.
- busy=1 in every non-IDLE state.

Optional Feature:
TLB_FILL_RR_EN: when defined, rand_index is a round-robin counter. It resets to 0, increments mod TLBNUM after each FILL EXEC cycle, and reaches every index including 0. When undefined, the LFSR described above is used.

Test Plan:
- WR, data_busy=0, op accepted at cycle 10 -> tlb_wen pulse at cycle 12 only, resp_valid at 13, busy 11..13.
- SRCH, data_busy=1 for 3 cycles after accept, s_found=1, s_index=7 -> tlbsrch_en after drain; srch_wb_en with srch_ne=0, srch_index=7.
- SRCH miss, s_found=0 -> srch_ne=1; no tlb_wen, tlb_fill_en or tlbinv_en ever asserted.
- INV op=5, asid=0x3A, vpn=0x1234 -> tlbinv_en for 1 cycle with the latched values, even if inputs change after accept.
- excp_flush during SWAIT -> no srch_wb_en, no resp_valid, IDLE next cycle. excp_flush during FILL EXEC -> tlb_fill_en still pulses, no resp_valid.
- 32 back-to-back FILLs: without macro, indices follow the LFSR from 00001 and never 0. With TLB_FILL_RR_EN, indices are 0..31 in order, then wrap to 0.
